instr_fetch: RTL and testbench

Instruction fetch stage feeding the opcode decoder and the rest of the datapath. Holds the PC and issues one 32-bit instruction read to instruction memory over a request/grant/response handshake. Presents the returned instruction, its PC and its opcode field to decode, and holds them until decode consumes them. Next PC is PC+4 or a branch target supplied with the consumed instruction.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_pc.sv | 38 +++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int OPCODE_W = 7;
  localparam int INSTR_W  = 32;
  localparam int PC_INCR  = 4;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// PC register with next-PC selection (sequential or redirect).
// FETCH_MISALIGN_CHECK_EN: flag misaligned redirects instead of masking them.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            consume,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;

  always_comb begin
    target = branch_target;
`ifndef FETCH_MISALIGN_CHECK_EN
    target[1:0] = 2'b00;
`endif
    pc_next = branch_taken ? target : pc + XLEN'(PC_INCR);
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = branch_taken && (branch_target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)          pc <= RESET_PC;
    else if (consume) pc <= pc_next;
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: FSM, single-outstanding imem handshake, held instruction.
// FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-target fault.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INSTR_W-1:0]  imem_rdata_i,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     branch_target_i,
  output logic                instr_valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                fault_o
);
  fetch_state_t       state, state_next;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    pc;
  logic               consume;
  logic               misalign;

  assign consume = (state == HOLD) && !stall_i;

  fetch_pc #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk           (clk_i),
    .rst           (rst_i),
    .consume       (consume),
    .branch_taken  (branch_taken_i),
    .branch_target (branch_target_i),
    .pc            (pc),
    .misalign      (misalign)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_next;
      // rvalid is only meaningful while a request is outstanding
      if (state == WAIT && imem_rvalid_i) instr_q <= imem_rdata_i;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (imem_gnt_i) state_next = WAIT;
      WAIT:    if (imem_rvalid_i) state_next = HOLD;
      HOLD:    if (!stall_i) state_next = misalign ? FAULT : REQ;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o    = (state == REQ);
    imem_addr_o   = pc;
    instr_valid_o = (state == HOLD);
    instr_o       = instr_q;
    opcode_o      = instr_q[OPCODE_W-1:0];
    pc_o          = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_o       = (state == FAULT);
`else
    fault_o       = 1'b0;
`endif
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fetch scoreboard (expected pc/instr queue).
module tb_instr_fetch;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic        fault_o;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } rec_t;
  rec_t sb[$];
  rec_t held;
  int passed = 0;
  int total  = 0;

  instr_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .opcode_o(opcode_o),
    .pc_o(pc_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Entered with DUT in REQ; leaves DUT in HOLD with the scoreboard entry checked.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int gnt_delay);
    for (int i = 0; i < gnt_delay; i++) begin
      check("req_held", {31'b0, imem_req_o}, 32'd1);
      check("addr_held", imem_addr_o, pc);
      tick();
    end
    check("req", {31'b0, imem_req_o}, 32'd1);
    check("addr", imem_addr_o, pc);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check("wait_req", {31'b0, imem_req_o}, 32'd0);
    check("wait_valid", {31'b0, instr_valid_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    sb.push_back('{pc: pc, instr: data});
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    check("hold_valid", {31'b0, instr_valid_o}, 32'd1);
    if (sb.size() == 0) begin
      total++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      held = sb.pop_front();
      check("instr", instr_o, held.instr);
      check("opcode", {25'b0, opcode_o}, {25'b0, held.instr[6:0]});
      check("pc", pc_o, held.pc);
    end
  endtask

  // Stalls n cycles (with a stray rvalid that must be ignored), then consumes.
  task automatic consume(input logic taken, input logic [31:0] target, input int nstall);
    for (int i = 0; i < nstall; i++) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      check("stall_instr", instr_o, held.instr);
      check("stall_pc", pc_o, held.pc);
      check("stall_req", {31'b0, imem_req_o}, 32'd0);
    end
    imem_rvalid_i   = 1'b0;
    stall_i         = 1'b0;
    branch_taken_i  = taken;
    branch_target_i = target;
    tick();
    stall_i         = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'hFFFF_FFF3;
  endtask

  initial begin
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    tick(); tick();
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_opcode", {25'b0, opcode_o}, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_fault", {31'b0, fault_o}, 32'd0);
    rst_i = 1'b0;
    tick();                                  // IDLE -> REQ
    fetch(32'h0, 32'h0000_0033, 0);
    consume(1'b0, 32'h0, 0);
    fetch(32'h4, 32'h0000_2083, 3);
    consume(1'b0, 32'h0, 5);
    fetch(32'h8, 32'h0000_0013, 0);
    consume(1'b1, 32'h10, 0);
    fetch(32'h10, 32'h0040_0063, 0);
    consume(1'b1, 32'h40, 0);
    fetch(32'h40, 32'h0000_0093, 1);
    consume(1'b1, 32'h10, 0);
    fetch(32'h10, 32'h0000_0113, 0);
    consume(1'b0, 32'h40, 0);
    fetch(32'h14, 32'h0000_0193, 0);
    consume(1'b1, 32'hFFFF_FFFC, 0);
    fetch(32'hFFFF_FFFC, 32'h0000_006F, 0);
    consume(1'b0, 32'h0, 2);
    fetch(32'h0, 32'h0000_0213, 0);
    consume(1'b1, 32'h42, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("fault", {31'b0, fault_o}, 32'd1);
      check("fault_req", {31'b0, imem_req_o}, 32'd0);
      check("fault_valid", {31'b0, instr_valid_o}, 32'd0);
      check("fault_pc", pc_o, 32'h42);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
    end
`else
    check("nofault", {31'b0, fault_o}, 32'd0);
    fetch(32'h40, 32'h0000_0293, 0);
    consume(1'b0, 32'h0, 0);
`endif
    // Reset while a request is outstanding; the late response must be dropped.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();                                  // IDLE -> REQ
    check("pre_wait_req", {31'b0, imem_req_o}, 32'd1);
    check("pre_wait_addr", imem_addr_o, 32'h0);
    imem_gnt_i = 1'b1;
    tick();                                  // REQ -> WAIT
    imem_gnt_i = 1'b0;
    rst_i = 1'b1;
    tick();                                  // reset in WAIT
    rst_i = 1'b0;
    check("wrst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("wrst_instr", instr_o, 32'h0);
    check("wrst_fault", {31'b0, fault_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0033;
    tick();                                  // stale rvalid in IDLE
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    check("stale_valid", {31'b0, instr_valid_o}, 32'd0);
    check("stale_instr", instr_o, 32'h0);
    fetch(32'h0, 32'h0000_0333, 0);
    consume(1'b0, 32'h0, 0);
    check("next_addr", imem_addr_o, 32'h4);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
